// File: rtl/mem_stage.sv
// Memory-access stage: runs loads/stores over a req/gnt/rvalid handshake,
// aligns load data, builds store byte enables and flags misaligned accesses.
module mem_stage #(
    parameter int DMEM_AW = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    output logic               in_ready_o,
    output logic               stall_o,
    input  logic [31:0]        alu_result_i,
    input  logic [31:0]        reg2_data_i,
    input  logic [4:0]         wb_addr_i,
    input  logic [2:0]         funct3_i,
    input  logic               mem_read_i,
    input  logic               mem_write_i,
    input  logic               wb_enable_i,
    output logic               dmem_req_o,
    input  logic               dmem_gnt_i,
    output logic [3:0]         dmem_we_o,
    output logic [DMEM_AW-1:0] dmem_addr_o,
    output logic [31:0]        dmem_wdata_o,
    input  logic               dmem_rvalid_i,
    input  logic [31:0]        dmem_rdata_i,
    output logic               valid_o,
    output logic [31:0]        wb_data_o,
    output logic [4:0]         wb_addr_o,
    output logic               wb_enable_o,
    output logic               misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t state_q, state_d;

    logic [31:0] alu_p0;
    logic [2:0]  funct3_p0;
    logic        store_p0;
    logic        wb_en_p0;
    logic [4:0]  wb_addr_p0;

    logic               req_d;
    logic [3:0]         we_d;
    logic [DMEM_AW-1:0] addr_d;
    logic [31:0]        wdata_d;
    logic               valid_d;
    logic [31:0]        wb_data_d;
    logic [4:0]         wb_addr_d;
    logic               wb_en_d;
    logic               misalign_d;

    logic is_mem_in;
    logic mis_in;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic m;
        m = 1'b0;
        if (size == 2'b01)
            m = lo[0];
        else if (size[1])
            m = (lo != 2'b00);
        return m;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   r = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign in_ready_o = (state_q == IDLE);
    assign stall_o    = !in_ready_o;

    assign is_mem_in = mem_read_i | mem_write_i;
    assign mis_in    = is_mem_in & is_misaligned(funct3_i[1:0], alu_result_i[1:0]);

    always_comb begin
        state_d    = state_q;
        req_d      = dmem_req_o;
        we_d       = dmem_we_o;
        addr_d     = dmem_addr_o;
        wdata_d    = dmem_wdata_o;
        valid_d    = 1'b0;
        wb_data_d  = wb_data_o;
        wb_addr_d  = wb_addr_o;
        wb_en_d    = wb_enable_o;
        misalign_d = misalign_o;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (!is_mem_in || mis_in) begin
                        // Retire immediately: ALU result or a refused misaligned access.
                        valid_d    = 1'b1;
                        wb_data_d  = alu_result_i;
                        wb_addr_d  = wb_addr_i;
                        wb_en_d    = wb_enable_i & !is_mem_in;
                        misalign_d = mis_in;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        addr_d  = alu_result_i[DMEM_AW+1:2];
                        we_d    = mem_write_i ? byte_enable(funct3_i[1:0], alu_result_i[1:0]) : 4'b0000;
                        if (mem_write_i)
                            wdata_d = store_data(funct3_i[1:0], reg2_data_i);
                    end
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    req_d = 1'b0;
                    we_d  = 4'b0000;
                    if (store_p0) begin
                        state_d    = IDLE;
                        valid_d    = 1'b1;
                        wb_data_d  = alu_p0;
                        wb_addr_d  = wb_addr_p0;
                        wb_en_d    = 1'b0;
                        misalign_d = 1'b0;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (dmem_rvalid_i) begin
                    state_d    = IDLE;
                    valid_d    = 1'b1;
                    wb_data_d  = load_align(funct3_p0, alu_p0[1:0], dmem_rdata_i);
                    wb_addr_d  = wb_addr_p0;
                    wb_en_d    = wb_en_p0;
                    misalign_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage boundary p0: instruction fields held for the duration of an access.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && valid_i) begin
            alu_p0     <= alu_result_i;
            funct3_p0  <= funct3_i;
            store_p0   <= mem_write_i;
            wb_en_p0   <= wb_enable_i;
            wb_addr_p0 <= wb_addr_i;
        end
    end

    // Stage boundary: registered memory-port and write-back outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 4'b0000;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            valid_o      <= 1'b0;
            wb_data_o    <= '0;
            wb_addr_o    <= '0;
            wb_enable_o  <= 1'b0;
            misalign_o   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dmem_req_o   <= req_d;
            dmem_we_o    <= we_d;
            dmem_addr_o  <= addr_d;
            dmem_wdata_o <= wdata_d;
            valid_o      <= valid_d;
            wb_data_o    <= wb_data_d;
            wb_addr_o    <= wb_addr_d;
            wb_enable_o  <= wb_en_d;
            misalign_o   <= misalign_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand sequences, and random
// instructions checked against an arithmetic reference model.
module tb_mem_stage;

    localparam int DMEM_AW = 14;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               valid_i = 1'b0;
    logic               in_ready_o, stall_o;
    logic [31:0]        alu_result_i = '0;
    logic [31:0]        reg2_data_i = '0;
    logic [4:0]         wb_addr_i = '0;
    logic [2:0]         funct3_i = '0;
    logic               mem_read_i = 1'b0, mem_write_i = 1'b0, wb_enable_i = 1'b0;
    logic               dmem_req_o;
    logic               dmem_gnt_i = 1'b0;
    logic [3:0]         dmem_we_o;
    logic [DMEM_AW-1:0] dmem_addr_o;
    logic [31:0]        dmem_wdata_o;
    logic               dmem_rvalid_i = 1'b0;
    logic [31:0]        dmem_rdata_i = '0;
    logic               valid_o;
    logic [31:0]        wb_data_o;
    logic [4:0]         wb_addr_o;
    logic               wb_enable_o, misalign_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage #(.DMEM_AW(DMEM_AW)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .in_ready_o(in_ready_o), .stall_o(stall_o),
        .alu_result_i(alu_result_i), .reg2_data_i(reg2_data_i), .wb_addr_i(wb_addr_i),
        .funct3_i(funct3_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .wb_enable_i(wb_enable_i), .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o),
        .wb_data_o(wb_data_o), .wb_addr_o(wb_addr_o), .wb_enable_o(wb_enable_o),
        .misalign_o(misalign_o)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] d;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        mr;
        logic        mw;
        logic        wbe;
        logic [31:0] rdata;
        int          gd;
        int          rv;
        logic [31:0] e_data;
        logic        e_wbe;
        logic        e_mis;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: derives expectations from access size, offset and sign rules.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int unsigned n, off;
        logic mem, mis;
        longint unsigned x;
        r = v;
        n = (v.f3[1:0] == 2'b00) ? 1 : (v.f3[1:0] == 2'b01) ? 2 : 4;
        off = int'(v.alu[1:0]);
        mem = v.mr | v.mw;
        mis = mem && ((v.alu % n) != 0);
        r.e_mis = mis;
        r.e_be = (v.mw && !mis) ? 4'(((1 << n) - 1) << off) : 4'b0000;
        if (n == 1)      r.e_wdata = 32'(v.d[7:0]) * 32'h0101_0101;
        else if (n == 2) r.e_wdata = 32'(v.d[15:0]) * 32'h0001_0001;
        else             r.e_wdata = v.d;
        x = (64'(v.rdata) >> (8 * off)) & ((64'd1 << (8 * n)) - 1);
        if (!v.f3[2] && n < 4 && x >= (64'd1 << (8 * n - 1)))
            x = x - (64'd1 << (8 * n));
        if (!mem || mis || v.mw) r.e_data = v.alu;
        else                     r.e_data = x[31:0];
        r.e_wbe = (!mem) ? v.wbe : ((mis || v.mw) ? 1'b0 : v.wbe);
        return r;
    endfunction

    task automatic drive(input vec_t v);
        alu_result_i = v.alu;
        reg2_data_i  = v.d;
        wb_addr_i    = v.rd;
        funct3_i     = v.f3;
        mem_read_i   = v.mr;
        mem_write_i  = v.mw;
        wb_enable_i  = v.wbe;
        valid_i      = 1'b1;
    endtask

    task automatic idle_inputs();
        valid_i = 1'b0;
        mem_read_i = 1'b0;
        mem_write_i = 1'b0;
        alu_result_i = $urandom;
        reg2_data_i = $urandom;
    endtask

    // Called just after a rising edge; returns just after the edge whose valid_o retires v.
    task automatic run(input vec_t v, input string t);
        logic [DMEM_AW-1:0] wa;
        wa = v.alu[DMEM_AW+1:2];
        chk({t, ".in_ready"}, in_ready_o, 1'b1);
        drive(v);
        dmem_gnt_i = 1'($urandom);
        dmem_rvalid_i = 1'($urandom);
        dmem_rdata_i = $urandom;
        @(posedge clk); #1;
        idle_inputs();
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b0;
        if (!(v.mr | v.mw) || v.e_mis) begin
            chk({t, ".req"}, dmem_req_o, 1'b0);
            chk({t, ".valid"}, valid_o, 1'b1);
            chk({t, ".mis"}, misalign_o, v.e_mis);
            chk({t, ".wbe"}, wb_enable_o, v.e_wbe);
            chk({t, ".data"}, wb_data_o, v.e_data);
            chk({t, ".wb_addr"}, wb_addr_o, v.rd);
        end else begin
            chk({t, ".valid_req"}, valid_o, 1'b0);
            chk({t, ".req"}, dmem_req_o, 1'b1);
            chk({t, ".stall"}, stall_o, 1'b1);
            chk({t, ".be"}, dmem_we_o, v.e_be);
            chk({t, ".addr"}, dmem_addr_o, wa);
            if (v.mw) chk({t, ".wdata"}, dmem_wdata_o, v.e_wdata);
            for (int i = 0; i < v.gd; i++) begin
                dmem_rvalid_i = 1'($urandom);
                @(posedge clk); #1;
                dmem_rvalid_i = 1'b0;
                chk({t, ".req_hold"}, dmem_req_o, 1'b1);
                chk({t, ".be_hold"}, dmem_we_o, v.e_be);
                chk({t, ".addr_hold"}, dmem_addr_o, wa);
                if (v.mw) chk({t, ".wdata_hold"}, dmem_wdata_o, v.e_wdata);
                chk({t, ".stall_hold"}, stall_o, 1'b1);
                chk({t, ".valid_wait"}, valid_o, 1'b0);
            end
            dmem_gnt_i = 1'b1;
            @(posedge clk); #1;
            dmem_gnt_i = 1'b0;
            chk({t, ".req_drop"}, dmem_req_o, 1'b0);
            if (v.mw) begin
                chk({t, ".st_valid"}, valid_o, 1'b1);
                chk({t, ".st_wbe"}, wb_enable_o, 1'b0);
                chk({t, ".st_mis"}, misalign_o, 1'b0);
            end else begin
                chk({t, ".ld_valid_gnt"}, valid_o, 1'b0);
                chk({t, ".ld_stall"}, stall_o, 1'b1);
                for (int i = 0; i < v.rv; i++) begin
                    dmem_gnt_i = 1'($urandom);
                    @(posedge clk); #1;
                    dmem_gnt_i = 1'b0;
                    chk({t, ".ld_valid_wait"}, valid_o, 1'b0);
                    chk({t, ".ld_req_wait"}, dmem_req_o, 1'b0);
                end
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i = v.rdata;
                @(posedge clk); #1;
                dmem_rvalid_i = 1'b0;
                dmem_rdata_i = $urandom;
                chk({t, ".ld_valid"}, valid_o, 1'b1);
                chk({t, ".ld_data"}, wb_data_o, v.e_data);
                chk({t, ".ld_wb_addr"}, wb_addr_o, v.rd);
                chk({t, ".ld_wbe"}, wb_enable_o, v.e_wbe);
                chk({t, ".ld_mis"}, misalign_o, 1'b0);
            end
        end
    endtask

    initial begin
        vec_t v;
        //          alu           d             rd     f3      mr mw wbe rdata         gd rv e_data        wbe mis be       wdata
        tbl[0]  = '{32'h0000_1234, 32'h0,        5'd5,  3'b000, 0, 0, 1, 32'h0,         0, 0, 32'h0000_1234, 1, 0, 4'b0000, 32'h0};
        tbl[1]  = '{32'h0000_5678, 32'h0,        5'd6,  3'b000, 0, 0, 1, 32'h0,         0, 0, 32'h0000_5678, 1, 0, 4'b0000, 32'h0};
        tbl[2]  = '{32'h0000_0103, 32'hAABBCCDD, 5'd0,  3'b000, 0, 1, 0, 32'h0,         3, 0, 32'h0000_0103, 0, 0, 4'b1000, 32'hDDDDDDDD};
        tbl[3]  = '{32'h0000_0002, 32'h0,        5'd7,  3'b000, 1, 0, 1, 32'h0080_0000, 0, 0, 32'hFFFF_FF80, 1, 0, 4'b0000, 32'h0};
        tbl[4]  = '{32'h0000_0002, 32'h0,        5'd7,  3'b100, 1, 0, 1, 32'h0080_0000, 0, 0, 32'h0000_0080, 1, 0, 4'b0000, 32'h0};
        tbl[5]  = '{32'h0000_0002, 32'h0,        5'd7,  3'b001, 1, 0, 1, 32'h8001_0000, 0, 0, 32'hFFFF_8001, 1, 0, 4'b0000, 32'h0};
        tbl[6]  = '{32'h0000_0006, 32'h0,        5'd8,  3'b010, 1, 0, 1, 32'h0,         0, 0, 32'h0000_0006, 0, 1, 4'b0000, 32'h0};
        tbl[7]  = '{32'h0000_0202, 32'h12345678, 5'd0,  3'b001, 0, 1, 0, 32'h0,         0, 0, 32'h0000_0202, 0, 0, 4'b1100, 32'h56785678};
        tbl[8]  = '{32'h0000_0040, 32'hCAFEBABE, 5'd0,  3'b010, 0, 1, 0, 32'h0,         1, 0, 32'h0000_0040, 0, 0, 4'b1111, 32'hCAFEBABE};
        tbl[9]  = '{32'h0000_0000, 32'h0,        5'd9,  3'b101, 1, 0, 1, 32'h1234_F00D, 1, 2, 32'h0000_F00D, 1, 0, 4'b0000, 32'h0};
        tbl[10] = '{32'h0000_0010, 32'h0,        5'd10, 3'b010, 1, 0, 1, 32'hDEAD_BEEF, 2, 1, 32'hDEAD_BEEF, 1, 0, 4'b0000, 32'h0};
        tbl[11] = '{32'h0000_0011, 32'h1,        5'd0,  3'b001, 0, 1, 0, 32'h0,         0, 0, 32'h0000_0011, 0, 1, 4'b0000, 32'h0};
        tbl[12] = '{32'h0000_0001, 32'h55,       5'd3,  3'b000, 1, 1, 1, 32'h0,         0, 0, 32'h0000_0001, 0, 0, 4'b0010, 32'h55555555};
        tbl[13] = '{32'h0000_0003, 32'h0,        5'd11, 3'b000, 1, 0, 1, 32'h7F00_0000, 0, 0, 32'h0000_007F, 1, 0, 4'b0000, 32'h0};
        tbl[14] = '{32'hFFFF_FFFF, 32'h0,        5'd12, 3'b111, 0, 0, 0, 32'h0,         0, 0, 32'hFFFF_FFFF, 0, 0, 4'b0000, 32'h0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", valid_o, 1'b0);
        chk("rst.req", dmem_req_o, 1'b0);
        chk("rst.we", dmem_we_o, 4'b0000);
        chk("rst.wbe", wb_enable_o, 1'b0);
        chk("rst.mis", misalign_o, 1'b0);
        chk("rst.data", wb_data_o, 32'h0);
        chk("rst.wb_addr", wb_addr_o, 5'd0);
        chk("rst.addr", dmem_addr_o, '0);
        chk("rst.wdata", dmem_wdata_o, 32'h0);
        chk("rst.ready", in_ready_o, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++)
            run(tbl[i], $sformatf("v%0d", i));
        @(posedge clk); #1;
        chk("tail.valid_pulse", valid_o, 1'b0);

        // Back-to-back ALU ops: consecutive valid_o, never stalled.
        run(tbl[0], "b2b0");
        chk("b2b.stall", stall_o, 1'b0);
        run(tbl[1], "b2b1");
        chk("b2b.stall2", stall_o, 1'b0);

        // Reset while waiting for the load response, then a stray rvalid.
        v = model('{32'h0000_0020, 32'h0, 5'd13, 3'b010, 1'b1, 1'b0, 1'b1, 32'h0,
                    0, 0, 32'h0, 1'b0, 1'b0, 4'b0, 32'h0});
        @(posedge clk); #1;
        drive(v);
        @(posedge clk); #1;
        idle_inputs();
        chk("rstseq.req", dmem_req_o, 1'b1);
        dmem_gnt_i = 1'b1;
        @(posedge clk); #1;
        dmem_gnt_i = 1'b0;
        chk("rstseq.resp_stall", stall_o, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstseq.valid", valid_o, 1'b0);
        chk("rstseq.ready", in_ready_o, 1'b1);
        chk("rstseq.req0", dmem_req_o, 1'b0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'h1111_2222;
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
        chk("rstseq.stray_valid", valid_o, 1'b0);
        chk("rstseq.stray_ready", in_ready_o, 1'b1);
        @(posedge clk); #1;
        chk("rstseq.stray_valid2", valid_o, 1'b0);
        run(tbl[0], "post_rst_alu");
        run(tbl[10], "post_rst_lw");

        // Random instructions against the reference model.
        for (int k = 0; k < 200; k++) begin
            int kind;
            kind = $urandom_range(0, 2);
            v.alu = $urandom & 32'h0000_FFFF;
            if (($urandom & 3) == 0) v.alu = $urandom;
            v.d = $urandom;
            v.rd = 5'($urandom);
            v.f3 = 3'($urandom);
            v.wbe = 1'($urandom);
            v.mr = (kind == 1) || (kind == 2 && ($urandom & 3) == 0);
            v.mw = (kind == 2);
            v.rdata = $urandom;
            v.gd = $urandom_range(0, 3);
            v.rv = $urandom_range(0, 3);
            v = model(v);
            run(v, $sformatf("rnd%0d", k));
            if (($urandom & 1) == 1) begin
                @(posedge clk); #1;
                chk($sformatf("rnd%0d.pulse", k), valid_o, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
